rggen_bit_field_rwx: RTL and testbench
======================================

// Module: rggen_bit_field_rwx
// PURPOSE
//  Generalised software/hardware-accessible bit field. It is the successor to the plain RW field.
//  - SW write semantics selectable: normal, W1C/W1S/W1T, W0C/W0S/W0T, WC/WS, read-only.
//  - SW read side effects selectable: none, read-clear, read-set.
//  - HW write, per-bit HW set and per-bit HW clear, with fixed precedence.
//  - Registered one-cycle write/read trigger pulses.
//  - Sits inside generated register blocks, one instance per field.
// PARAMETERS
//  WIDTH            8    field width in bits (1..64)
//  INITIAL_VALUE    '0   [WIDTH-1:0] reset value of the field
//  SW_WRITE_ACTION  0    0 NORMAL,1 W1C,2 W1S,3 W1T,4 W0C,5 W0S,6 W0T,7 WC,8 WS,9 NONE
//  SW_READ_ACTION   0    0 NONE,1 RC (read-clear),2 RS (read-set)
//  HW_WRITE_EN      0    1: i_hw_write_enable/i_hw_write_data are honoured; 0: ignored
//  HW_SET_EN        0    1: i_hw_set is honoured; 0: ignored
//  HW_CLEAR_EN      0    1: i_hw_clear is honoured; 0: ignored
// PORTS
//  i_clk              in   1      clock; one clock domain
//  i_rst_n            in   1      asynchronous reset, active-low
//  bit_field_if       mod  -      rggen_bit_field_if.bit_field (valid, read_mask, write_mask, write_data, read_data, value)
//  i_hw_write_enable  in   1      HW whole-field load strobe
//  i_hw_write_data    in   WIDTH  HW load data
//  i_hw_set           in   WIDTH  per-bit HW set
//  i_hw_clear         in   WIDTH  per-bit HW clear
//  o_value            out  WIDTH  current field value
//  o_write_trigger    out  1      one-cycle pulse after any SW write access
//  o_read_trigger     out  1      one-cycle pulse after any SW read access
// BEHAVIOUR
//  - Reset (async, i_rst_n=0):
//    - value = INITIAL_VALUE; o_write_trigger = 0; o_read_trigger = 0.
//    - Reset mid-access discards the access and any pending trigger.
//  - Access qualification:
//    - wr = valid & |write_mask.
//    - rd = valid & |read_mask & ~wr; write wins if both masks are non-zero.
//  - read_data = value and bit_field_if.value = value, combinational.
//    - read_data is always the pre-side-effect value.
//  - SW write (when wr); v = value, d = write_data, m = write_mask:
//    - NORMAL: (d&m)|(v&~m).
//    - W1C: v&~(d&m).   W1S: v|(d&m).   W1T: v^(d&m).
//    - W0C: v&~(~d&m).  W0S: v|(~d&m).  W0T: v^(~d&m).
//    - WC: v&~m.        WS: v|m.        NONE: v.
//  - SW read side effect (when rd):
//    - RC: v&~read_mask.
//    - RS: v|read_mask.
//    - NONE: v.
//  - Next-value precedence, all evaluated in the same cycle, per bit:
//    1. s = SW result (write or read side effect, else v).
//    2. h = (HW_WRITE_EN & i_hw_write_enable) ? i_hw_write_data : s.
//    3. h |= HW_SET_EN ? i_hw_set : 0.
//    4. next = h & ~(HW_CLEAR_EN ? i_hw_clear : 0).
//    - Consequences: a HW set in the same cycle as a W1C or RC clear keeps the bit at 1.
//    - HW clear beats HW set.
//  - Update latency: value updates on the next rising i_clk edge.
//    - o_value reflects the new value in that cycle.
//  - Triggers:
//    - o_write_trigger <= wr and o_read_trigger <= rd, registered.
//    - High exactly one cycle, the cycle after the access.
//    - Back-to-back accesses produce back-to-back pulses.
//    - A trigger fires even when SW_WRITE_ACTION = NONE.
//  - No wrap or saturation concerns.
//    - Toggle modes XOR in place.
//    - Unused HW inputs must not affect value; they are tied off in the generator.
// TESTING
//  1. Reset, WIDTH=8, INITIAL_VALUE=8'h5A -> o_value=8'h5A, both triggers 0, read_data=8'h5A.
//  2. NORMAL, v=8'h5A, write d=8'hFF m=8'h0F -> v=8'h5F next cycle; o_write_trigger=1 for exactly one cycle.
//  3. W1C, v=8'hF0, write d=8'h30 m=8'hFF with i_hw_set=8'h10 in the same cycle -> v=8'hD0 (set wins).
//  4. RC, v=8'h81, read read_mask=8'hFF -> read_data=8'h81 that cycle, v=8'h00 next; o_read_trigger pulses once.
//  5. HW_WRITE_EN=1, W1T, v=8'h0F, write d=8'hFF plus hw_write 8'hAA plus hw_clear=8'h02 -> v=8'hA8.
//  6. i_rst_n asserted asynchronously mid-cycle during a write -> o_value=INITIAL_VALUE immediately, no trigger pulse after release.

Source files
------------

// File: rtl/rggen_bit_field_rwx_if.sv
// Register-block side view of one bit field: access strobes and masks in,
// read data and current field value out.
interface rggen_bit_field_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] read_mask;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport bit_field (
    input  valid, read_mask, write_mask, write_data,
    output read_data, value
  );

  modport master (
    output valid, read_mask, write_mask, write_data,
    input  read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_rwx.sv
// Generalised SW/HW accessible bit field: selectable SW write/read side effects,
// HW load/set/clear with fixed precedence, and registered access trigger pulses.
module rggen_bit_field_rwx #(
  parameter int               WIDTH           = 8,
  parameter logic [WIDTH-1:0] INITIAL_VALUE   = '0,
  parameter int               SW_WRITE_ACTION = 0,
  parameter int               SW_READ_ACTION  = 0,
  parameter bit               HW_WRITE_EN     = 1'b0,
  parameter bit               HW_SET_EN       = 1'b0,
  parameter bit               HW_CLEAR_EN     = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic                 i_hw_write_enable,
  input  logic [WIDTH-1:0]     i_hw_write_data,
  input  logic [WIDTH-1:0]     i_hw_set,
  input  logic [WIDTH-1:0]     i_hw_clear,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_write_trigger,
  output logic                 o_read_trigger
);

  localparam int SW_W_NORMAL = 0;
  localparam int SW_W_W1C    = 1;
  localparam int SW_W_W1S    = 2;
  localparam int SW_W_W1T    = 3;
  localparam int SW_W_W0C    = 4;
  localparam int SW_W_W0S    = 5;
  localparam int SW_W_W0T    = 6;
  localparam int SW_W_WC     = 7;
  localparam int SW_W_WS     = 8;

  localparam int SW_R_RC = 1;
  localparam int SW_R_RS = 2;

  function automatic logic [WIDTH-1:0] sw_write_result(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH-1:0] r;
    case (SW_WRITE_ACTION)
      SW_W_NORMAL: r = (d & m) | (v & ~m);
      SW_W_W1C:    r = v & ~(d & m);
      SW_W_W1S:    r = v | (d & m);
      SW_W_W1T:    r = v ^ (d & m);
      SW_W_W0C:    r = v & ~(~d & m);
      SW_W_W0S:    r = v | (~d & m);
      SW_W_W0T:    r = v ^ (~d & m);
      SW_W_WC:     r = v & ~m;
      SW_W_WS:     r = v | m;
      default:     r = v;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] sw_read_result(
    input logic [WIDTH-1:0] v,
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH-1:0] r;
    case (SW_READ_ACTION)
      SW_R_RC: r = v & ~m;
      SW_R_RS: r = v | m;
      default: r = v;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] value_p1;
  logic             wr_trig_p1;
  logic             rd_trig_p1;

  logic             wr_p0;
  logic             rd_p0;
  logic [WIDTH-1:0] sw_p0;
  logic [WIDTH-1:0] hw_p0;
  logic [WIDTH-1:0] next_p0;

  // Stage p0: access decode and next-value precedence (SW, then HW load, set, clear)
  always_comb begin
    wr_p0 = bit_field_if.valid & (|bit_field_if.write_mask);
    rd_p0 = bit_field_if.valid & (|bit_field_if.read_mask) & ~wr_p0;

    sw_p0 = value_p1;
    if (wr_p0) begin
      sw_p0 = sw_write_result(value_p1, bit_field_if.write_data, bit_field_if.write_mask);
    end else if (rd_p0) begin
      sw_p0 = sw_read_result(value_p1, bit_field_if.read_mask);
    end

    hw_p0   = (HW_WRITE_EN && i_hw_write_enable) ? i_hw_write_data : sw_p0;
    hw_p0   = hw_p0 | (HW_SET_EN ? i_hw_set : '0);
    next_p0 = hw_p0 & ~(HW_CLEAR_EN ? i_hw_clear : '0);
  end

  // Stage p1: field state and trigger pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_p1   <= INITIAL_VALUE;
      wr_trig_p1 <= 1'b0;
      rd_trig_p1 <= 1'b0;
    end else begin
      value_p1   <= next_p0;
      wr_trig_p1 <= wr_p0;
      rd_trig_p1 <= rd_p0;
    end
  end

  assign bit_field_if.read_data = value_p1;
  assign bit_field_if.value     = value_p1;
  assign o_value                = value_p1;
  assign o_write_trigger        = wr_trig_p1;
  assign o_read_trigger         = rd_trig_p1;

endmodule

// File: tb/tb_rggen_bit_field_rwx.sv
// Directed bench for rggen_bit_field_rwx across several write/read/HW configurations.
module tb_rggen_bit_field_rwx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Inputs for instances whose HW ports are disabled; driven with junk to prove they are ignored
  logic       jwe;
  logic [7:0] jwd, jset, jclr;
  // HW inputs for the HW-enabled instances
  logic       we1, we3;
  logic [7:0] wd1, set1, clr1, wd3, set3, clr3;

  logic [7:0] val0, val1, val2, val3, val4, val5;
  logic       wt0, wt1, wt2, wt3, wt4, wt5;
  logic       rt0, rt1, rt2, rt3, rt4, rt5;

  rggen_bit_field_if #(.WIDTH(8)) if0 ();
  rggen_bit_field_if #(.WIDTH(8)) if1 ();
  rggen_bit_field_if #(.WIDTH(8)) if2 ();
  rggen_bit_field_if #(.WIDTH(8)) if3 ();
  rggen_bit_field_if #(.WIDTH(8)) if4 ();
  rggen_bit_field_if #(.WIDTH(8)) if5 ();

  // NORMAL, no HW
  rggen_bit_field_rwx #(.WIDTH(8), .INITIAL_VALUE(8'h5A), .SW_WRITE_ACTION(0), .SW_READ_ACTION(0),
    .HW_WRITE_EN(1'b0), .HW_SET_EN(1'b0), .HW_CLEAR_EN(1'b0)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if0),
    .i_hw_write_enable(jwe), .i_hw_write_data(jwd), .i_hw_set(jset), .i_hw_clear(jclr),
    .o_value(val0), .o_write_trigger(wt0), .o_read_trigger(rt0));

  // W1C with HW set
  rggen_bit_field_rwx #(.WIDTH(8), .INITIAL_VALUE(8'hF0), .SW_WRITE_ACTION(1), .SW_READ_ACTION(0),
    .HW_WRITE_EN(1'b0), .HW_SET_EN(1'b1), .HW_CLEAR_EN(1'b0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if1),
    .i_hw_write_enable(we1), .i_hw_write_data(wd1), .i_hw_set(set1), .i_hw_clear(clr1),
    .o_value(val1), .o_write_trigger(wt1), .o_read_trigger(rt1));

  // Read-clear
  rggen_bit_field_rwx #(.WIDTH(8), .INITIAL_VALUE(8'h81), .SW_WRITE_ACTION(0), .SW_READ_ACTION(1),
    .HW_WRITE_EN(1'b0), .HW_SET_EN(1'b0), .HW_CLEAR_EN(1'b0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if2),
    .i_hw_write_enable(jwe), .i_hw_write_data(jwd), .i_hw_set(jset), .i_hw_clear(jclr),
    .o_value(val2), .o_write_trigger(wt2), .o_read_trigger(rt2));

  // W1T with full HW load/set/clear
  rggen_bit_field_rwx #(.WIDTH(8), .INITIAL_VALUE(8'h0F), .SW_WRITE_ACTION(3), .SW_READ_ACTION(0),
    .HW_WRITE_EN(1'b1), .HW_SET_EN(1'b1), .HW_CLEAR_EN(1'b1)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if3),
    .i_hw_write_enable(we3), .i_hw_write_data(wd3), .i_hw_set(set3), .i_hw_clear(clr3),
    .o_value(val3), .o_write_trigger(wt3), .o_read_trigger(rt3));

  // Write NONE with read-set
  rggen_bit_field_rwx #(.WIDTH(8), .INITIAL_VALUE(8'h00), .SW_WRITE_ACTION(9), .SW_READ_ACTION(2),
    .HW_WRITE_EN(1'b0), .HW_SET_EN(1'b0), .HW_CLEAR_EN(1'b0)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if4),
    .i_hw_write_enable(jwe), .i_hw_write_data(jwd), .i_hw_set(jset), .i_hw_clear(jclr),
    .o_value(val4), .o_write_trigger(wt4), .o_read_trigger(rt4));

  // W0S
  rggen_bit_field_rwx #(.WIDTH(8), .INITIAL_VALUE(8'h00), .SW_WRITE_ACTION(5), .SW_READ_ACTION(0),
    .HW_WRITE_EN(1'b0), .HW_SET_EN(1'b0), .HW_CLEAR_EN(1'b0)) u5 (
    .i_clk(clk), .i_rst_n(rst_n), .bit_field_if(if5),
    .i_hw_write_enable(jwe), .i_hw_write_data(jwd), .i_hw_set(jset), .i_hw_clear(jclr),
    .o_value(val5), .o_write_trigger(wt5), .o_read_trigger(rt5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    if0.valid = 0; if0.read_mask = 0; if0.write_mask = 0; if0.write_data = 0;
    if1.valid = 0; if1.read_mask = 0; if1.write_mask = 0; if1.write_data = 0;
    if2.valid = 0; if2.read_mask = 0; if2.write_mask = 0; if2.write_data = 0;
    if3.valid = 0; if3.read_mask = 0; if3.write_mask = 0; if3.write_data = 0;
    if4.valid = 0; if4.read_mask = 0; if4.write_mask = 0; if4.write_data = 0;
    if5.valid = 0; if5.read_mask = 0; if5.write_mask = 0; if5.write_data = 0;
    jwe = 0; jwd = 0; jset = 0; jclr = 0;
    we1 = 0; wd1 = 0; set1 = 0; clr1 = 0;
    we3 = 0; wd3 = 0; set3 = 0; clr3 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_value0", val0, 8'h5A);
    chk("rst_rdata0", if0.read_data, 8'h5A);
    chk("rst_ifval0", if0.value, 8'h5A);
    chk("rst_wtrig0", wt0, 1'b0);
    chk("rst_rtrig0", rt0, 1'b0);
    chk("rst_value1", val1, 8'hF0);
    chk("rst_value2", val2, 8'h81);
    chk("rst_value3", val3, 8'h0F);

    // Junk on disabled HW inputs from here on
    jwe = 1; jwd = 8'h00; jset = 8'hFF; jclr = 8'hFF;

    // NORMAL write
    if0.valid = 1; if0.write_mask = 8'h0F; if0.write_data = 8'hFF;
    #1 chk("normal_pre_rdata", if0.read_data, 8'h5A);
    @(negedge clk);
    if0.valid = 0; if0.write_mask = 0;
    chk("normal_value", val0, 8'h5F);
    chk("normal_wtrig", wt0, 1'b1);
    chk("normal_rtrig", rt0, 1'b0);
    @(negedge clk);
    chk("normal_wtrig_end", wt0, 1'b0);
    chk("normal_hold", val0, 8'h5F);

    // Back-to-back writes, second with both masks set (write wins)
    if0.valid = 1; if0.write_mask = 8'hF0; if0.write_data = 8'h00;
    @(negedge clk);
    chk("b2b_value1", val0, 8'h0F);
    chk("b2b_wtrig1", wt0, 1'b1);
    if0.write_mask = 8'hFF; if0.write_data = 8'hC3; if0.read_mask = 8'hFF;
    @(negedge clk);
    if0.valid = 0; if0.write_mask = 0; if0.read_mask = 0;
    chk("b2b_value2", val0, 8'hC3);
    chk("b2b_wtrig2", wt0, 1'b1);
    chk("b2b_rtrig2", rt0, 1'b0);
    @(negedge clk);
    chk("b2b_wtrig_end", wt0, 1'b0);

    // W1C with simultaneous HW set
    if1.valid = 1; if1.write_mask = 8'hFF; if1.write_data = 8'h30; set1 = 8'h10;
    @(negedge clk);
    if1.valid = 0; if1.write_mask = 0; set1 = 0;
    chk("w1c_set_value", val1, 8'hD0);
    chk("w1c_wtrig", wt1, 1'b1);

    // Read-clear
    if2.valid = 1; if2.read_mask = 8'hFF;
    #1 chk("rc_rdata", if2.read_data, 8'h81);
    @(negedge clk);
    if2.valid = 0; if2.read_mask = 0;
    chk("rc_value", val2, 8'h00);
    chk("rc_rtrig", rt2, 1'b1);
    chk("rc_wtrig", wt2, 1'b0);
    @(negedge clk);
    chk("rc_rtrig_end", rt2, 1'b0);

    // W1T with HW load, HW set and HW clear on the same bit
    if3.valid = 1; if3.write_mask = 8'hFF; if3.write_data = 8'hFF;
    we3 = 1; wd3 = 8'hAA; clr3 = 8'h02; set3 = 8'h02;
    @(negedge clk);
    if3.valid = 0; if3.write_mask = 0; we3 = 0; clr3 = 0; set3 = 0;
    chk("w1t_hw_value", val3, 8'hA8);
    set3 = 8'h01;
    @(negedge clk);
    set3 = 0;
    chk("hw_set_only", val3, 8'hA9);
    chk("hw_set_wtrig", wt3, 1'b0);

    // Write NONE still triggers; read-set
    if4.valid = 1; if4.write_mask = 8'hFF; if4.write_data = 8'hFF;
    @(negedge clk);
    if4.write_mask = 0; if4.read_mask = 8'h81;
    chk("none_value", val4, 8'h00);
    chk("none_wtrig", wt4, 1'b1);
    @(negedge clk);
    if4.valid = 0; if4.read_mask = 0;
    chk("rs_value", val4, 8'h81);
    chk("rs_rtrig", rt4, 1'b1);
    chk("rs_wtrig", wt4, 1'b0);

    // W0S
    if5.valid = 1; if5.write_mask = 8'h3C; if5.write_data = 8'h0F;
    @(negedge clk);
    if5.valid = 0; if5.write_mask = 0;
    chk("w0s_value", val5, 8'h30);

    // Async reset in the middle of a write
    if0.valid = 1; if0.write_mask = 8'hFF; if0.write_data = 8'h11;
    #2 rst_n = 1'b0;
    #1 chk("arst_value", val0, 8'h5A);
    chk("arst_wtrig", wt0, 1'b0);
    chk("arst_value3", val3, 8'h0F);
    @(negedge clk);
    if0.valid = 0; if0.write_mask = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_post_wtrig", wt0, 1'b0);
    chk("arst_post_value", val0, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
